rv32i_result_monitor: RTL

RV32I_RESULT_MONITOR -- requirements
Module: rv32i_result_monitor

---
 rtl/rv32i_result_monitor.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_result_monitor.sv
// Purpose : sequences a core-under-test through reset and run, watches its result bus,
//           logs every result change into a trace FIFO, and judges pass / timeout.
// Latency : trace head and status flags are registered; trace_data/stamp read the head
//           entry combinationally.
// Backpressure: trace_ready low holds the head entry. A change while full with no pop
//           is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               level request to begin/restart a run (honoured in IDLE and DONE)
//   expected, result    value the result bus must settle to / monitored result bus
//   core_rst            active-high reset driven to the core under test
//   trace_valid/ready   trace FIFO handshake, trace_data/trace_stamp = head entry
//   done, pass, timeout, overflow   run status flags
//   signature           rotate-xor signature over every result change of the run
module rv32i_result_monitor #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 8,    // power of two, >= 2
  parameter int RST_CYCLES    = 4,    // >= 1
  parameter int STABLE_CYCLES = 8,    // >= 1
  parameter int TIMEOUT       = 1024, // >= 1
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] result,
  output logic             core_rst,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [WIDTH-1:0] trace_data,
  output logic [CNT_W-1:0] trace_stamp,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             overflow,
  output logic [WIDTH-1:0] signature
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [AW:0]      FULL_CNT   = DEPTH[AW:0];
  localparam logic [RW-1:0]    RST_LOAD   = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0]    STABLE_LST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [RW-1:0]    rst_cnt_q,   rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [SW-1:0]    stable_q,    stable_d;
  logic [WIDTH-1:0] sig_q,       sig_d;
  logic [WIDTH-1:0] prev_q,      prev_d;
  logic             first_q,     first_d;
  logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [AW:0]      count_q,     count_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;
  logic             timeout_q,   timeout_d;
  logic             overflow_q,  overflow_d;

  // Trace storage: no reset needed, reads are masked while the FIFO is empty.
  logic [WIDTH-1:0] mem_data  [DEPTH];
  logic [CNT_W-1:0] mem_stamp [DEPTH];

  logic pop;
  logic full;
  logic change;
  logic match;
  logic push_ok;
  logic wr_en;
  logic clear_run;

  assign trace_valid = (count_q != '0);
  assign full        = (count_q == FULL_CNT);
  assign pop         = trace_valid && trace_ready;

  assign trace_data  = trace_valid ? mem_data[rd_ptr_q]  : '0;
  assign trace_stamp = trace_valid ? mem_stamp[rd_ptr_q] : '0;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign signature   = sig_q;

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    stable_d    = stable_q;
    sig_d       = sig_q;
    prev_d      = prev_q;
    first_d     = first_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    overflow_d  = overflow_q;
    core_rst    = 1'b1;
    change      = 1'b0;
    match       = 1'b0;
    push_ok     = 1'b0;
    wr_en       = 1'b0;
    clear_run   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) clear_run = 1'b1;
      end

      S_RESET: begin
        if (rst_cnt_q == '0) state_d = S_RUN;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end

      S_RUN: begin
        core_rst = 1'b0;
        // The first RUN cycle always counts as a change so the trace
        // starts with the initial result value.
        change   = first_q || (result != prev_q);
        first_d  = 1'b0;
        prev_d   = result;
        if (change) sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ result;

        match    = (result == expected);
        stable_d = match ? stable_q + 1'b1 : '0;

        // Pass is checked first so a pass landing on the last allowed
        // cycle wins over the timeout.
        if (match && (stable_q == STABLE_LST)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (cycle_cnt_q == CYC_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        core_rst = 1'b0;
        if (start) clear_run = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    // A full FIFO still accepts a change when the head leaves the same cycle.
    push_ok = change && (!full || pop);
    if (change && full && !pop) overflow_d = 1'b1;

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Starting a run wipes the previous run's trace and status, overriding
    // any pop that happens on the same edge.
    if (clear_run) begin
      state_d     = S_RESET;
      rst_cnt_d   = RST_LOAD;
      cycle_cnt_d = '0;
      stable_d    = '0;
      sig_d       = '0;
      prev_d      = '0;
      first_d     = 1'b1;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      stable_q    <= '0;
      sig_q       <= '0;
      prev_q      <= '0;
      first_q     <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      stable_q    <= stable_d;
      sig_q       <= sig_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q]  <= result;
      mem_stamp[wr_ptr_q] <= cycle_cnt_q;
    end
  end

endmodule
